// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mc_ctrl_pkg
//  Brief   : Shared types and constants for the multicycle main control FSM:
//            state encoding, datapath mux select codes, opcode classes.
//  Rev     : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

   // Main FSM states; the numeric values are visible on the State debug port.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_MULEX    = 4'd10,
      S_MULWB    = 4'd11
   } state_t;

   // ALU source A select
   localparam logic [1:0] SRCA_REG    = 2'b00;
   localparam logic [1:0] SRCA_PC     = 2'b01;
   localparam logic [1:0] SRCA_ALUOUT = 2'b10;

   // ALU source B select
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_IMM    = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Instr[27:26] classes
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // Instr[7:4] pattern identifying a multiply in the data-processing space
   localparam logic [3:0] MUL_ID = 4'b1001;

   // States that wait on the memory handshake before moving on
   function automatic logic waits_on_memory(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module  : mc_ctrl_decode
//  Brief   : Combinational classifier used in the DECODE state: maps the
//            instruction class fields to the first execution state and flags
//            undecodable encodings.
//  Rev     : 1.0  initial release
// ============================================================================
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [1:0] op,
   input  logic       funct_imm,   // Instr[25]: immediate operand flag
   input  logic [3:0] mul_id,
   output state_t     next_state,
   output logic       illegal
);

   // Multiply shares the register-operand data-processing space, so it is
   // tested first; an immediate operand can never be a multiply.
   always_comb begin
      next_state = S_FETCH;
      illegal    = 1'b0;
      if ((op == OP_DP) && (mul_id == MUL_ID) && !funct_imm) begin
         next_state = S_MULEX;
      end else if (op == OP_MEM) begin
         next_state = S_MEMADR;
      end else if (op == OP_DP) begin
         next_state = funct_imm ? S_EXECUTEI : S_EXECUTER;
      end else if (op == OP_BR) begin
         next_state = S_BRANCH;
      end else begin
         next_state = S_FETCH;
         illegal    = 1'b1;
      end
   end

endmodule : mc_ctrl_decode
`default_nettype wire

// File: rtl/mc_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : mc_main_fsm
//  Brief   : Main sequencing FSM for the multicycle ARM core. Drives all
//            datapath strobes and mux selects; fetch and data accesses wait
//            on MemReady so the core tolerates a multi-cycle memory.
//  Rev     : 1.0  initial release
// ============================================================================
module mc_main_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
)(
   input  logic               clk,
   input  logic               reset,      // synchronous, active low
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   input  logic [3:0]         MulId,
   input  logic               MemReady,
   output logic               IRWrite,
   output logic               NextPC,
   output logic               RegW,
   output logic               MemW,
   output logic               Branch,
   output logic               AdrSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic               ALUOp,
   output logic               Mul,
   output logic               AuxW,
   output logic               Illegal,
   output logic [STATE_W-1:0] State
);

   state_t state;
   state_t dec_next;
   logic   dec_illegal;

   // Funct bits only the ALU decoder cares about
   logic unused_funct_bits;
   assign unused_funct_bits = ^{Funct[4], Funct[2:1]};

   mc_ctrl_decode u_decode (
      .op         (Op),
      .funct_imm  (Funct[5]),
      .mul_id     (MulId),
      .next_state (dec_next),
      .illegal    (dec_illegal)
   );

   assign State = STATE_W'(state);

   // State register: sequence the instruction, stalling on memory handshakes
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:    if (MemReady) state <= S_DECODE;
            S_DECODE:   state <= dec_next;
            S_MEMADR:   state <= Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (MemReady) state <= S_MEMWB;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWR:    if (MemReady) state <= S_FETCH;
            S_EXECUTER: state <= S_ALUWB;
            S_EXECUTEI: state <= S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_BRANCH:   state <= S_FETCH;
            S_MULEX:    state <= S_MULWB;
            S_MULWB:    state <= S_FETCH;
            default:    state <= S_FETCH;
         endcase
      end
   end

   // Output decode from the current state; enables are squashed during reset
   // so an aborted instruction never leaves a partial write behind.
   always_comb begin
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = SRCA_REG;
      ALUSrcB   = SRCB_REG;
      ResultSrc = RES_ALUOUT;
      ALUOp     = 1'b0;
      Mul       = 1'b0;
      AuxW      = 1'b0;
      Illegal   = 1'b0;
      case (state)
         S_FETCH: begin
            AdrSrc    = 1'b0;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = MemReady;
            NextPC    = MemReady;
         end
         S_DECODE: begin
            // PC+4 again so r15 reads as PC+8
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            Illegal   = dec_illegal;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_IMM;
            ALUOp   = 1'b0;
         end
         S_MEMRD: begin
            AdrSrc    = 1'b1;
            ResultSrc = RES_ALUOUT;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegW      = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc    = 1'b1;
            ResultSrc = RES_ALUOUT;
            MemW      = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_REG;
            ALUOp   = 1'b1;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_IMM;
            ALUOp   = 1'b1;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            RegW      = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA   = SRCA_ALUOUT;
            ALUSrcB   = SRCB_IMM;
            ALUOp     = 1'b0;
            ResultSrc = RES_ALURESULT;
            Branch    = 1'b1;
         end
         S_MULEX: begin
            Mul     = 1'b1;
            ALUSrcA = SRCA_REG;
            ALUSrcB = SRCB_REG;
            ALUOp   = 1'b1;
            // Long multiply: datapath delays this so it lands with MULWB
            AuxW    = Funct[3];
         end
         S_MULWB: begin
            Mul       = 1'b1;
            ResultSrc = RES_ALUOUT;
            RegW      = 1'b1;
         end
         default: begin
         end
      endcase
      if (!reset) begin
         IRWrite = 1'b0;
         NextPC  = 1'b0;
         RegW    = 1'b0;
         MemW    = 1'b0;
         Branch  = 1'b0;
         AuxW    = 1'b0;
         Illegal = 1'b0;
      end
   end

endmodule : mc_main_fsm
`default_nettype wire

// File: tb/tb_mc_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mc_main_fsm
//  Brief   : Directed bench for mc_main_fsm with an instruction-class model
//            compared every cycle, plus literal spot checks.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mc_main_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] MulId;
   logic       MemReady;
   logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic       ALUOp, Mul, AuxW, Illegal;
   logic [3:0] State;

   int total = 0;
   int bad   = 0;

   mc_main_fsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulId(MulId),
      .MemReady(MemReady), .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW),
      .MemW(MemW), .Branch(Branch), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .Mul(Mul),
      .AuxW(AuxW), .Illegal(Illegal), .State(State)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Per-state output row: adrsrc, srcA, srcB, result, aluop, mul, regw, memw, branch
   typedef struct packed {
      logic       adr;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] r;
      logic       aluop;
      logic       mul;
      logic       regw;
      logic       memw;
      logic       branch;
   } row_t;

   row_t tbl [12];

   initial begin
      tbl[0]  = '{1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // fetch
      tbl[1]  = '{1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // decode
      tbl[2]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // memadr
      tbl[3]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // memrd
      tbl[4]  = '{1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // memwb
      tbl[5]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // memwr
      tbl[6]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // executer
      tbl[7]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // executei
      tbl[8]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // aluwb
      tbl[9]  = '{1'b0, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // branch
      tbl[10] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // mulex
      tbl[11] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // mulwb
   end

   // Model: the current step plus the remaining steps of the instruction class
   int m_state = 0;
   bit mvalid  = 1'b0;
   int path[$];

   always @(negedge clk) begin
      row_t        r;
      logic        en;
      logic [19:0] exp_v;
      logic [19:0] act_v;
      if (mvalid) begin
         r     = tbl[m_state];
         en    = reset;
         exp_v = {4'(m_state),
                  en & (m_state == 0) & MemReady,
                  en & (m_state == 0) & MemReady,
                  en & r.regw, en & r.memw, en & r.branch,
                  r.adr, r.a, r.b, r.r, r.aluop, r.mul,
                  en & (m_state == 10) & Funct[3],
                  en & (m_state == 1) & (Op == 2'b11)};
         act_v = {State, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Mul, AuxW, Illegal};
         chk("cycle", {12'd0, act_v}, {12'd0, exp_v});
      end
      // inputs hold until the next rising edge, so advance the model now
      if (!reset) begin
         m_state = 0;
         path.delete();
         mvalid  = 1'b1;
      end else if (mvalid) begin
         if ((m_state == 0 || m_state == 3 || m_state == 5) && !MemReady) begin
            m_state = m_state;
         end else if (m_state == 0) begin
            m_state = 1;
         end else begin
            if (m_state == 1) begin
               path.delete();
               if (Op == 2'b00 && MulId == 4'b1001 && !Funct[5]) begin
                  path.push_back(10); path.push_back(11);
               end else if (Op == 2'b01) begin
                  path.push_back(2);
                  if (Funct[0]) begin path.push_back(3); path.push_back(4); end
                  else          path.push_back(5);
               end else if (Op == 2'b00) begin
                  path.push_back(Funct[5] ? 7 : 6); path.push_back(8);
               end else if (Op == 2'b10) begin
                  path.push_back(9);
               end
            end
            if (path.size() > 0) m_state = path.pop_front();
            else                 m_state = 0;
         end
      end
   end

   task automatic cyc(input logic mr, input logic rs);
      @(posedge clk); #1;
      MemReady = mr;
      reset    = rs;
      @(negedge clk);
   endtask

   task automatic fetch(input logic [1:0] op, input logic [5:0] f, input logic [3:0] m, input logic mr);
      @(posedge clk); #1;
      Op = op; Funct = f; MulId = m;
      MemReady = mr;
      reset    = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; MemReady = 1'b1; Op = 2'b00; Funct = 6'd0; MulId = 4'd0;
      cyc(1, 0); chk("rst_irw", IRWrite, 0); chk("rst_state", State, 0);
      cyc(1, 0);
      // ADD register
      fetch(2'b00, 6'b001000, 4'b0000, 1); chk("add_f_irw", IRWrite, 1); chk("add_f_st", State, 0);
      cyc(1, 1); chk("add_d_st", State, 1); chk("add_d_irw", IRWrite, 0);
      cyc(1, 1); chk("add_x_st", State, 6); chk("add_x_regw", RegW, 0);
      cyc(1, 1); chk("add_wb_st", State, 8); chk("add_wb_regw", RegW, 1);
      // LDR with two wait cycles in MEMRD
      fetch(2'b01, 6'b011001, 4'b0000, 1);
      cyc(1, 1);
      cyc(1, 1); chk("ldr_adr", State, 2);
      cyc(0, 1); chk("ldr_rd0", State, 3);
      cyc(0, 1); chk("ldr_rd1", State, 3);
      cyc(1, 1); chk("ldr_rd2", State, 3);
      cyc(1, 1); chk("ldr_wb_st", State, 4); chk("ldr_wb_regw", RegW, 1); chk("ldr_wb_res", ResultSrc, 2'b01);
      // STR with a fetch stall
      fetch(2'b01, 6'b011000, 4'b0000, 0); chk("ldr_len", State, 0); chk("str_stall_irw", IRWrite, 0);
      chk("str_stall_npc", NextPC, 0);
      cyc(1, 1); chk("str_f_irw", IRWrite, 1); chk("str_f_npc", NextPC, 1);
      cyc(1, 1);
      cyc(1, 1);
      cyc(1, 1); chk("str_wr_st", State, 5); chk("str_wr_memw", MemW, 1);
      // STR aborted by reset while waiting in MEMWR
      fetch(2'b01, 6'b011000, 4'b0000, 1);
      cyc(1, 1);
      cyc(1, 1);
      cyc(0, 1); chk("abort_memw_hi", MemW, 1);
      cyc(0, 0); chk("abort_memw_lo", MemW, 0);
      cyc(1, 0); chk("abort_rst_memw", MemW, 0);
      cyc(1, 0);
      cyc(1, 1); chk("abort_post_st", State, 0);
      cyc(1, 1);
      cyc(1, 1);
      cyc(1, 1);
      // UMULL
      fetch(2'b00, 6'b001001, 4'b1001, 1);
      cyc(1, 1);
      cyc(1, 1); chk("umull_ex_st", State, 10); chk("umull_ex_mul", Mul, 1); chk("umull_ex_aux", AuxW, 1);
      cyc(1, 1); chk("umull_wb_st", State, 11); chk("umull_wb_regw", RegW, 1); chk("umull_wb_aux", AuxW, 0);
      // MUL
      fetch(2'b00, 6'b000000, 4'b1001, 1);
      cyc(1, 1);
      cyc(1, 1); chk("mul_ex_aux", AuxW, 0);
      cyc(1, 1); chk("mul_wb_st", State, 11);
      // immediate data-processing whose low bits look like a multiply
      fetch(2'b00, 6'b101000, 4'b1001, 1);
      cyc(1, 1);
      cyc(1, 1); chk("dpi_st", State, 7);
      cyc(1, 1); chk("dpi_wb_st", State, 8);
      // B
      fetch(2'b10, 6'b000000, 4'b0000, 1);
      cyc(1, 1);
      cyc(1, 1); chk("b_st", State, 9); chk("b_srca", ALUSrcA, 2'b10); chk("b_res", ResultSrc, 2'b10);
      chk("b_branch", Branch, 1);
      // undecodable
      fetch(2'b11, 6'b000000, 4'b0000, 1); chk("b_len", State, 0);
      cyc(1, 1); chk("ill_st", State, 1); chk("ill_pulse", Illegal, 1);
      cyc(1, 1); chk("ill_next", State, 0); chk("ill_clear", Illegal, 0);
      cyc(1, 1);
      cyc(1, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mc_main_fsm
`default_nettype wire
